// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter generator.
//   pc_state_e  : control state (boot, run, halt)
//   redir_sel_e : which redirect source won the priority select
//   DefaultResetVector / DefaultInstrBytes : parameter defaults
package pc_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    RedirNone = 2'd0,
    RedirBr   = 2'd1,
    RedirJalr = 2'd2,
    RedirTrap = 2'd3
  } redir_sel_e;

  localparam logic [31:0] DefaultResetVector = 32'h0000_0000;
  localparam int unsigned DefaultInstrBytes  = 4;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch handshake between the PC generator and instruction fetch.
//   pc       : current fetch address (generator -> fetch)
//   pc_valid : pc is a valid fetch request (generator -> fetch)
//   pc_ready : fetch accepts pc this cycle (fetch -> generator)
interface pc_gen_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pc_ready;

  modport master (
    output pc,
    output pc_valid,
    input  pc_ready
  );

  modport slave (
    input  pc,
    input  pc_valid,
    output pc_ready
  );

endinterface

// File: rtl/pc_redirect_mux.sv
// Combinational redirect select: trap > jalr > branch/jal, target adders and,
// when PC_MISALIGN_TRAP_EN is defined, the misaligned-target check.
//   br_*/jalr_*/trap_*  : redirect requests and operands
//   redirect_valid      : some redirect is requested
//   redirect_sel        : winning source
//   redirect_pc         : target to load (trap_vec on a misaligned target)
//   misalign            : selected jalr/branch target was misaligned (macro only)
module pc_redirect_mux
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_base,
  input  logic [XLEN-1:0] br_offset,
  input  logic            jalr_taken,
  input  logic [XLEN-1:0] jalr_rs1,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  output logic            redirect_valid,
  output redir_sel_e      redirect_sel,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign,
`endif
  output logic [XLEN-1:0] redirect_pc
);

  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;

  assign br_tgt   = br_base + br_offset;
  assign jalr_sum = jalr_rs1 + jalr_imm;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};

  always_comb begin
    redirect_valid = 1'b0;
    redirect_sel   = RedirNone;
    redirect_pc    = br_tgt;
`ifdef PC_MISALIGN_TRAP_EN
    misalign       = 1'b0;
`endif
    if (trap_req) begin
      redirect_valid = 1'b1;
      redirect_sel   = RedirTrap;
      redirect_pc    = trap_vec;
    end else if (jalr_taken) begin
      redirect_valid = 1'b1;
      redirect_sel   = RedirJalr;
      redirect_pc    = jalr_tgt;
    end else if (br_taken) begin
      redirect_valid = 1'b1;
      redirect_sel   = RedirBr;
      redirect_pc    = br_tgt;
    end
`ifdef PC_MISALIGN_TRAP_EN
    // Trap vectors are trusted; only computed targets are checked.
    if ((redirect_sel == RedirJalr || redirect_sel == RedirBr) &&
        (redirect_pc[1:0] != 2'b00)) begin
      misalign    = 1'b1;
      redirect_pc = trap_vec;
    end
`endif
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator with fetch handshake, prioritised redirects,
// halt/resume control and a flush pulse for downstream stages.
// Optional feature: define PC_MISALIGN_TRAP_EN to divert misaligned jalr/branch
// targets to trap_vec and pulse misalign_err; otherwise misalign_err is 0.
//   clk, reset     : clock and synchronous active-high reset
//   fetch          : pc / pc_valid / pc_ready handshake (master side)
//   br_*, jalr_*   : branch/jal and jalr redirect requests and operands
//   trap_req/vec   : trap redirect request and handler address
//   halt_req       : stop issuing fetches; resume_req restarts them
//   flush          : one-cycle pulse aligned with a redirected pc
//   halted         : high while in the halt state
//   misalign_err   : misaligned-target pulse (optional feature)
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DefaultResetVector),
  parameter int unsigned     INSTR_BYTES  = DefaultInstrBytes
) (
  input  logic            clk,
  input  logic            reset,
  pc_gen_unit_if.master   fetch,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_base,
  input  logic [XLEN-1:0] br_offset,
  input  logic            jalr_taken,
  input  logic [XLEN-1:0] jalr_rs1,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  input  logic            resume_req,
  output logic            flush,
  output logic            halted,
  output logic            misalign_err
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;

  logic            redirect_valid;
  redir_sel_e      redirect_sel;
  logic [XLEN-1:0] redirect_pc;
  logic            take;
  logic            accept;

`ifdef PC_MISALIGN_TRAP_EN
  logic mux_misalign;
  logic misalign_q, misalign_d;
`endif

  pc_redirect_mux #(
    .XLEN (XLEN)
  ) u_redirect_mux (
    .br_taken       (br_taken),
    .br_base        (br_base),
    .br_offset      (br_offset),
    .jalr_taken     (jalr_taken),
    .jalr_rs1       (jalr_rs1),
    .jalr_imm       (jalr_imm),
    .trap_req       (trap_req),
    .trap_vec       (trap_vec),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign       (mux_misalign),
`endif
    .redirect_pc    (redirect_pc)
  );

  // During boot only a trap may redirect.
  assign take   = redirect_valid && ((state_q != StBoot) || (redirect_sel == RedirTrap));
  assign accept = (state_q == StRun) && fetch.pc_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;

    // A redirect wins over sequential advance and discards an unaccepted pc.
    if (take) begin
      pc_d    = redirect_pc;
      flush_d = 1'b1;
    end else if (accept) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end

    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (halt_req && !trap_req) state_d = StHalt;
      end
      StHalt: begin
        if (resume_req || trap_req) state_d = StRun;
      end
      default: state_d = StBoot;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_d = take && mux_misalign;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_VECTOR;
      flush_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign fetch.pc       = pc_q;
  assign fetch.pc_valid = (state_q == StRun);
  assign halted         = (state_q == StHalt);
  assign flush          = flush_q;

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_ready;
  logic        br_taken, jalr_taken, trap_req, halt_req, resume_req;
  logic [31:0] br_base, br_offset, jalr_rs1, jalr_imm, trap_vec;
  logic        flush, halted, misalign_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_gen_unit_if #(.XLEN(32)) fetch_if ();
  assign fetch_if.pc_ready = pc_ready;

  pc_gen_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .INSTR_BYTES  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch        (fetch_if),
    .br_taken     (br_taken),
    .br_base      (br_base),
    .br_offset    (br_offset),
    .jalr_taken   (jalr_taken),
    .jalr_rs1     (jalr_rs1),
    .jalr_imm     (jalr_imm),
    .trap_req     (trap_req),
    .trap_vec     (trap_vec),
    .halt_req     (halt_req),
    .resume_req   (resume_req),
    .flush        (flush),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: mode 0 = boot, 1 = run, 2 = halt.
  int          m_mode = 0;
  logic [31:0] m_pc   = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the current inputs for one edge; the model predicts the outputs after it.
  task automatic tick();
    exp_t        e;
    logic        redir;
    logic        mis;
    logic [31:0] tgt;
    int          next_mode;
    e = '0;
    if (reset) begin
      m_pc   = 32'h0;
      m_mode = 0;
    end else begin
      redir = 1'b0;
      mis   = 1'b0;
      tgt   = 32'h0;
      if (trap_req) begin
        redir = 1'b1;
        tgt   = trap_vec;
      end else if (jalr_taken) begin
        redir = 1'b1;
        tgt   = (jalr_rs1 + jalr_imm) & 32'hFFFF_FFFE;
      end else if (br_taken) begin
        redir = 1'b1;
        tgt   = br_base + br_offset;
      end
`ifdef PC_MISALIGN_TRAP_EN
      if (redir && !trap_req && (tgt % 4 != 0)) begin
        mis = 1'b1;
        tgt = trap_vec;
      end
`endif
      if (m_mode == 0 && !trap_req) begin
        redir = 1'b0;
        mis   = 1'b0;
      end
      if (m_mode == 0)      next_mode = 1;
      else if (m_mode == 1) next_mode = (halt_req && !trap_req) ? 2 : 1;
      else                  next_mode = (resume_req || trap_req) ? 1 : 2;
      if (redir)                       m_pc = tgt;
      else if (m_mode == 1 && pc_ready) m_pc = m_pc + 32'd4;
      m_mode  = next_mode;
      e.flush = redir;
      e.mis   = mis;
    end
    e.pc     = m_pc;
    e.valid  = (m_mode == 1);
    e.halted = (m_mode == 2);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    br_taken   = 1'b0;
    jalr_taken = 1'b0;
    trap_req   = 1'b0;
    halt_req   = 1'b0;
    resume_req = 1'b0;
  endtask

  // Monitor: every edge the DUT presents a new output set; compare with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",           fetch_if.pc,              e.pc);
        chk("pc_valid",     32'(fetch_if.pc_valid),   32'(e.valid));
        chk("flush",        32'(flush),               32'(e.flush));
        chk("halted",       32'(halted),              32'(e.halted));
        chk("misalign_err", 32'(misalign_err),        32'(e.mis));
      end
    end
  end

  initial begin
    int budget;
    reset     = 1'b1;
    pc_ready  = 1'b1;
    br_base   = '0; br_offset = '0; jalr_rs1 = '0; jalr_imm = '0; trap_vec = '0;
    idle_inputs();

    // 1. reset then sequential fetch
    tick(); tick();
    reset = 1'b0;
    chk("tp1_boot_pc", fetch_if.pc, 32'h0);
    chk("tp1_boot_valid", 32'(fetch_if.pc_valid), 32'h0);
    tick();
    chk("tp1_run_valid", 32'(fetch_if.pc_valid), 32'h1);
    tick(); chk("tp1_pc4", fetch_if.pc, 32'h4);
    tick(); chk("tp1_pc8", fetch_if.pc, 32'h8);

    // 2. backpressure
    pc_ready = 1'b0;
    tick(); tick(); tick();
    chk("tp2_hold", fetch_if.pc, 32'h8);
    pc_ready = 1'b1;
    tick(); chk("tp2_pcC", fetch_if.pc, 32'hC);

    // 3. simultaneous redirects, then jalr alone
    trap_req = 1'b1; trap_vec = 32'h100;
    jalr_taken = 1'b1; jalr_rs1 = 32'h200; jalr_imm = 32'h5;
    br_taken = 1'b1; br_base = 32'h40; br_offset = 32'h4;
    tick(); chk("tp3_trap", fetch_if.pc, 32'h100);
    chk("tp3_flush", 32'(flush), 32'h1);
    idle_inputs(); jalr_taken = 1'b1;
    tick(); chk("tp3_jalr", fetch_if.pc, 32'h204);
    idle_inputs();

    // 4. branch under backpressure, then wrap
    pc_ready = 1'b0;
    br_taken = 1'b1; br_base = 32'h40; br_offset = 32'hFFFF_FFF8;
    tick(); chk("tp4_br", fetch_if.pc, 32'h38);
    br_base = 32'hFFFF_FFFC; br_offset = 32'h8;
    tick(); chk("tp4_wrap", fetch_if.pc, 32'h4);
    idle_inputs();
    tick(); chk("tp4_noflush", 32'(flush), 32'h0);

    // 5. halt, redirect while halted, resume
    br_taken = 1'b1; br_base = 32'h10; br_offset = 32'h0;
    tick();
    idle_inputs(); halt_req = 1'b1;
    tick();
    chk("tp5_halted", 32'(halted), 32'h1);
    chk("tp5_pc", fetch_if.pc, 32'h10);
    idle_inputs(); br_taken = 1'b1; br_base = 32'h80;
    tick(); chk("tp5_br_halt", fetch_if.pc, 32'h80);
    chk("tp5_still_halted", 32'(halted), 32'h1);
    idle_inputs(); resume_req = 1'b1;
    tick(); chk("tp5_resume", 32'(fetch_if.pc_valid), 32'h1);
    idle_inputs();

    // 6. misaligned branch target
    trap_vec = 32'h300; br_taken = 1'b1; br_base = 32'h40; br_offset = 32'h2;
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    chk("tp6_pc", fetch_if.pc, 32'h300);
    chk("tp6_mis", 32'(misalign_err), 32'h1);
`else
    chk("tp6_pc", fetch_if.pc, 32'h42);
    chk("tp6_mis", 32'(misalign_err), 32'h0);
`endif
    idle_inputs();

    // Mid-operation reset overrides a trap
    reset = 1'b1; trap_req = 1'b1; pc_ready = 1'b1;
    tick(); chk("rst_mid_pc", fetch_if.pc, 32'h0);
    reset = 1'b0; idle_inputs();

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      pc_ready   = ($urandom_range(0, 3) != 0);
      trap_req   = ($urandom_range(0, 15) == 0);
      jalr_taken = ($urandom_range(0, 15) == 0);
      br_taken   = ($urandom_range(0, 7) == 0);
      halt_req   = ($urandom_range(0, 15) == 0);
      resume_req = ($urandom_range(0, 3) == 0);
      br_base    = $urandom;
      br_offset  = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 255), 2'b00};
      jalr_rs1   = $urandom;
      jalr_imm   = $urandom;
      trap_vec   = $urandom;
      tick();
    end
    reset = 1'b0; idle_inputs();

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised program-counter generator; successor to the single-cycle PC register.
- Adds configurable width and vectors, a valid/ready handshake to instruction fetch, and prioritised redirects (trap, jalr, branch/jal).
- Adds a halt/resume state machine and a flush pulse for downstream pipeline stages.
- Sits between the control/execute stages and the instruction memory interface.

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  output  XLEN  current fetch address.
- pc_valid  output  1  pc is a valid fetch request.
- pc_ready  input  1  fetch accepts pc this cycle.
- br_taken  input  1  branch/jal redirect request.
- br_base  input  XLEN  PC of the branching instruction.
- br_offset  input  XLEN  signed offset.
- jalr_taken  input  1  jalr redirect request.
- jalr_rs1  input  XLEN  jalr base register value.
- jalr_imm  input  XLEN  signed immediate.
- trap_req  input  1  trap redirect request.
- trap_vec  input  XLEN  trap handler address (mtvec).
- halt_req  input  1  stop issuing fetches.
- resume_req  input  1  restart issuing fetches.
- flush  output  1  one-cycle pulse when a redirect is taken.
- halted  output  1  high in HALT state.
- misalign_err  output  1  misaligned-target pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Single clock domain; reset is synchronous and active-high; all state updates on the rising edge of clk.
- On reset:
  - pc=RESET_VECTOR, pc_valid=0, flush=0, halted=0, misalign_err=0, state=BOOT.
  - Reset asserted mid-operation overrides all other inputs the same cycle.
- States:
  - BOOT -> RUN unconditionally after one cycle; pc_valid=0 in BOOT.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0, halted=1.
- Transitions:
  - RUN -> HALT when halt_req=1 and no trap_req. pc is held. A handshake in that same cycle still completes: pc advances by INSTR_BYTES.
  - HALT -> RUN on resume_req=1 or trap_req=1.
  - halt_req and resume_req together in HALT -> RUN. The same pair in RUN -> HALT (halt wins).
- Redirect priority: trap_req > jalr_taken > br_taken.
  - Trap target = trap_vec.
  - Jalr target = (jalr_rs1 + jalr_imm) with bit0 cleared.
  - Branch/jal target = br_base + br_offset.
- Redirect timing:
  - A redirect loads its target into pc on the next edge, regardless of pc_ready.
  - An unaccepted current pc is discarded.
  - flush=1 for exactly the cycle after the redirect is sampled, aligned with the new pc.
  - In BOOT, redirects other than trap are ignored.
  - In HALT, a jalr or branch redirect updates pc but the state stays HALT.
- Sequential advance:
  - Only in RUN with pc_valid & pc_ready and no redirect: pc <= pc + INSTR_BYTES.
- Backpressure: with pc_valid=1 and pc_ready=0, pc is held stable indefinitely.
- Arithmetic: all additions are XLEN-bit modulo 2^XLEN, with no overflow detection. Example: pc=FFFF_FFFC advances to 0000_0000.
- Latency: redirect to new pc is one cycle; accept to next pc is one cycle.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A jalr or branch target with target[1:0] != 0 does not load the target; pc <= trap_vec instead.
  - misalign_err=1 and flush=1 for one cycle.
  - A trap target is not checked.
- Undefined:
  - Targets are loaded as computed; jalr still clears bit0.
  - misalign_err is tied to 0.

Decomposition:
- Shared package pc_pkg holds:
  - the state enum (BOOT, RUN, HALT);
  - the redirect-select enum (NONE, BR, JALR, TRAP);
  - the default RESET_VECTOR and INSTR_BYTES constants.
- One sub-module: pc_redirect_mux. It is combinational: priority select, target adders and misalign check. It outputs redirect_valid and redirect_pc.
- State machine and pc register stay in pc_gen_unit.

Test Plan:
1. Reset with pc_ready=1:
   - pc=0, pc_valid=0 in cycle 1.
   - Then pc_valid=1 and pc=0, 4, 8 on successive cycles.
2. Backpressure:
   - pc=8 and pc_ready=0 for 3 cycles -> pc holds 8.
   - Restoring pc_ready -> pc=C.
3. Simultaneous redirects:
   - trap_req (trap_vec=100) with jalr_taken (rs1=200, imm=5) and br_taken -> pc=100 next cycle, flush=1 for one cycle.
   - Jalr alone -> pc=204.
4. Branch:
   - br_base=40, br_offset=FFFF_FFF8 with pc_ready=0 -> pc=38, flush pulse.
   - br_base=FFFF_FFFC, br_offset=8 -> pc=0000_0004 (wrap).
5. Halt and resume:
   - halt_req in RUN at pc=10 without accept -> halted=1, pc_valid=0, pc=10.
   - br_taken to 80 while halted -> pc=80, halted stays 1.
   - resume_req -> pc_valid=1 at 80.
6. With PC_MISALIGN_TRAP_EN:
   - br target 0000_0042 -> pc=trap_vec, misalign_err=1.
   - Without the macro -> pc=0000_0042, misalign_err=0.
